// File: rtl/mem_store_pkg.sv
// mem_store_pkg
//   Shared definitions for the store write path: func3 encodings for the
//   store flavours, strobe width, the buffered store entry layout and a
//   helper that maps func3 to the unshifted byte strobe.
//   Build option: MEM_STORE_MISALIGN_SPLIT_EN (see mem_store_unit).
package mem_store_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // One word-aligned memory write as held in the store buffer.
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } store_entry_t;

    // Unshifted strobe; any func3 other than SB/SH behaves as SW.
    function automatic logic [STRB_W-1:0] base_strobe(input logic [2:0] func3);
        case (func3)
            F3_SB:   base_strobe = 4'b0001;
            F3_SH:   base_strobe = 4'b0011;
            default: base_strobe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_unit_align.sv
// store_align
//   Purely combinational lane alignment of one store request.
//   Ports:
//     addr_i       byte address of the store
//     func3_i      store size (SB/SH/SW, others as SW)
//     data_i       rs2 value, unshifted
//     lo_o         word-aligned entry covering the low word
//     hi_o         entry for the following word (only meaningful if misaligned)
//     misaligned_o store spills into the following word
module store_align
    import mem_store_pkg::*;
(
    input  logic [XLEN-1:0] addr_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] data_i,
    output store_entry_t    lo_o,
    output store_entry_t    hi_o,
    output logic            misaligned_o
);

    logic [1:0]          byte_off;
    logic [2*STRB_W-1:0] strb8;
    logic [2*XLEN-1:0]   data64;
    logic [XLEN-1:0]     lo_addr;

    assign byte_off = addr_i[1:0];

    // Shift across a two-word window so the spill-over lands in the upper half.
    assign strb8   = {{STRB_W{1'b0}}, base_strobe(func3_i)} << byte_off;
    assign data64  = {{XLEN{1'b0}}, data_i} << {byte_off, 3'b000};
    assign lo_addr = {addr_i[XLEN-1:2], 2'b00};

    assign lo_o.addr  = lo_addr;
    assign lo_o.wdata = data64[XLEN-1:0];
    assign lo_o.wstrb = strb8[STRB_W-1:0];

    // Wraps modulo 2^32 at the top of the address space.
    assign hi_o.addr  = lo_addr + 32'd4;
    assign hi_o.wdata = data64[2*XLEN-1:XLEN];
    assign hi_o.wstrb = strb8[2*STRB_W-1:STRB_W];

    assign misaligned_o = |strb8[2*STRB_W-1:STRB_W];

endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit
//   Turns SB/SH/SW requests into word-aligned memory writes with byte
//   strobes, buffered in a DEPTH-entry FIFO.
//   Build option: MEM_STORE_MISALIGN_SPLIT_EN -- when defined, misaligned
//   stores are split into two ordered word writes; otherwise they are
//   dropped and flagged on misalign_o.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     st_valid_i/ready_o   request handshake
//     st_addr_i/func3_i/data_i  store request fields
//     mem_req_o/gnt_i      memory write handshake for the head entry
//     mem_addr_o/wdata_o/wstrb_o  head entry
//     misalign_o           one-cycle pulse for a dropped misaligned store
//     empty_o              nothing buffered and no split pending
//
//   Handshakes: a request transfers on a clock edge where st_valid_i and
//   st_ready_o are both 1; st_ready_o never looks at st_valid_i. The head
//   entry leaves on an edge where mem_req_o and mem_gnt_i are both 1; while
//   mem_req_o waits for a grant the mem_* outputs do not change.
module mem_store_unit
    import mem_store_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_valid_i,
    output logic               st_ready_o,
    input  logic [WIDTH-1:0]   st_addr_i,
    input  logic [2:0]         st_func3_i,
    input  logic [WIDTH-1:0]   st_data_i,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [WIDTH-1:0]   mem_addr_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    output logic [WIDTH/8-1:0] mem_wstrb_o,
    output logic               misalign_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    store_entry_t     lo_entry;
    store_entry_t     hi_entry;
    logic             misaligned;

    store_entry_t     fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             misalign_q, misalign_d;

    logic             not_full;
    logic             xfer;
    logic             push;
    logic             pop;
    store_entry_t     push_entry;
    store_entry_t     head;

    store_align u_align (
        .addr_i       (st_addr_i),
        .func3_i      (st_func3_i),
        .data_i       (st_data_i),
        .lo_o         (lo_entry),
        .hi_o         (hi_entry),
        .misaligned_o (misaligned)
    );

    // Fullness is judged on the registered count only, so a pop in the
    // same cycle never opens room for a push.
    assign not_full   = count_q < CNT_W'(DEPTH);
    assign st_ready_o = not_full && (state_q == ST_IDLE) && !rst;
    assign xfer       = st_valid_i && st_ready_o;
    assign pop        = (count_q != '0) && mem_gnt_i;

`ifdef MEM_STORE_MISALIGN_SPLIT_EN
    store_entry_t hold_q, hold_d;
`else
    logic unused_hi;
    assign unused_hi = ^hi_entry;
`endif

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = lo_entry;
        misalign_d = 1'b0;
`ifdef MEM_STORE_MISALIGN_SPLIT_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
`ifdef MEM_STORE_MISALIGN_SPLIT_EN
                    push = 1'b1;
                    if (misaligned) begin
                        hold_d  = hi_entry;
                        state_d = ST_SPLIT;
                    end
`else
                    // Misaligned stores are accepted but never written.
                    push       = !misaligned;
                    misalign_d = misaligned;
`endif
                end
            end
`ifdef MEM_STORE_MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                if (not_full) begin
                    push       = 1'b1;
                    push_entry = hold_q;
                    state_d    = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef MEM_STORE_MISALIGN_SPLIT_EN
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end
`endif

    assign head        = fifo_q[rd_ptr_q];
    assign mem_req_o   = (count_q != '0);
    assign mem_addr_o  = head.addr;
    assign mem_wdata_o = head.wdata;
    assign mem_wstrb_o = head.wstrb;
    assign misalign_o  = misalign_q;
    assign empty_o     = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit
//   Directed bench for mem_store_unit. Inputs change on the falling edge,
//   outputs are sampled on the falling edge (plus #1 where a combinational
//   path from an input is involved). Expected memory writes are queued by
//   hand and compared in order whenever the DUT issues a granted write.
//   Build option: MEM_STORE_MISALIGN_SPLIT_EN selects the split expectations.
module tb_mem_store_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [31:0] st_addr_i;
    logic [2:0]  st_func3_i;
    logic [31:0] st_data_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        misalign_o;
    logic        empty_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [67:0] exp_q[$];
    bit          acc;
    int          k;
    logic [67:0] head_v;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    mem_store_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid_i  (st_valid_i),
        .st_ready_o  (st_ready_o),
        .st_addr_i   (st_addr_i),
        .st_func3_i  (st_func3_i),
        .st_data_i   (st_data_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .misalign_o  (misalign_o),
        .empty_o     (empty_o)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_st(input logic v, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d);
        st_valid_i = v;
        st_addr_i  = a;
        st_func3_i = f3;
        st_data_i  = d;
    endtask

    // Called on a falling edge with inputs already set: records whether the
    // request transfers and scores any granted write at the coming edge.
    task automatic tick(output bit accepted);
        #1;
        accepted = st_valid_i && st_ready_o;
        if (mem_req_o && mem_gnt_i) begin
            if (exp_q.size() == 0)
                check("spurious_write_pending", exp_q.size(), 1);
            else
                check("write", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit a;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(a);
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        mem_gnt_i = 1'b0;
        set_st(1'b0, 32'h0, 3'b010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", st_ready_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_misalign", misalign_o, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", st_ready_o, 1);
        @(negedge clk);

        // SB at byte 3, immediate grant
        mem_gnt_i = 1'b1;
        set_st(1'b1, 32'h0000_1003, 3'b000, 32'hDEAD_BEEF);
        check("t1_no_bypass", mem_req_o, 0);
        tick(acc);
        check("t1_acc", acc, 1);
        st_valid_i = 1'b0;
        check("t1_req_next_cycle", mem_req_o, 1);
        exp_q.push_back({32'h0000_1000, 32'hEF00_0000, 4'b1000});
        tick(acc);
        check("t1_empty_after", empty_o, 1);

        // SH then SW, ordered
        set_st(1'b1, 32'h0000_2002, 3'b001, 32'h1234_ABCD);
        tick(acc);
        check("t2_acc_sh", acc, 1);
        exp_q.push_back({32'h0000_2000, 32'hABCD_0000, 4'b1100});
        set_st(1'b1, 32'h0000_2004, 3'b010, 32'hCAFE_F00D);
        tick(acc);
        check("t2_acc_sw", acc, 1);
        exp_q.push_back({32'h0000_2004, 32'hCAFE_F00D, 4'b1111});
        st_valid_i = 1'b0;
        drain("t2_drained");

        // Fill with no grant, then grant with valid held
        mem_gnt_i = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            set_st(1'b1, 32'h0000_4000 + 32'(4 * k), 3'b010, 32'h1111_0000 + 32'(k));
            tick(acc);
            if (acc) begin
                exp_q.push_back({32'h0000_4000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111});
                k++;
            end
        end
        check("t3_accepts", k, DEPTH);
        #1;
        check("t3_full_ready", st_ready_o, 0);
        check("t3_head", {mem_addr_o, mem_wdata_o, mem_wstrb_o},
              {32'h0000_4000, 32'h1111_0000, 4'b1111});
        tick(acc);
        head_v = {mem_addr_o, mem_wdata_o, mem_wstrb_o};
        check("t3_head_hold", head_v, {32'h0000_4000, 32'h1111_0000, 4'b1111});
        mem_gnt_i = 1'b1;
        tick(acc);
        check("t3_no_full_bypass", acc, 0);
        for (int c = 0; c < 5 && k < DEPTH + 1; c++) begin
            set_st(1'b1, 32'h0000_4000 + 32'(4 * k), 3'b010, 32'h1111_0000 + 32'(k));
            tick(acc);
            if (acc) begin
                exp_q.push_back({32'h0000_4000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111});
                k++;
            end
        end
        check("t3_fifth_accepted", k, DEPTH + 1);
        st_valid_i = 1'b0;
        drain("t3_drained");

        // Misaligned SW at byte 1
        mem_gnt_i = 1'b1;
        set_st(1'b1, 32'h0000_3001, 3'b010, 32'hAABB_CCDD);
`ifdef MEM_STORE_MISALIGN_SPLIT_EN
        exp_q.push_back({32'h0000_3000, 32'hBBCC_DD00, 4'b1110});
        exp_q.push_back({32'h0000_3004, 32'h0000_00AA, 4'b0001});
`endif
        tick(acc);
        check("t4_acc", acc, 1);
        st_valid_i = 1'b0;
`ifdef MEM_STORE_MISALIGN_SPLIT_EN
        #1;
        check("t4_split_ready", st_ready_o, 0);
        check("t4_split_req", mem_req_o, 1);
        check("t4_split_no_flag", misalign_o, 0);
        drain("t4_drained");
`else
        check("t4_flag", misalign_o, 1);
        check("t4_no_req", mem_req_o, 0);
        check("t4_empty", empty_o, 1);
        tick(acc);
        check("t4_flag_one_cycle", misalign_o, 0);
        check("t4_empty_after", empty_o, 1);
        check("t4_no_req_after", mem_req_o, 0);
`endif

        // Reset with entries buffered (and a split pending when enabled)
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, 32'h0000_5000 + 32'(4 * i), 3'b010, 32'h5555_0000 + 32'(i));
            tick(acc);
            check("t5_fill_acc", acc, 1);
        end
        set_st(1'b1, 32'h0000_5001, 3'b010, 32'h5A5A_5A5A);
        tick(acc);
        check("t5_misaligned_acc", acc, 1);
        st_valid_i = 1'b0;
        rst = 1'b1;
        tick(acc);
        #1;
        check("t5_rst_req", mem_req_o, 0);
        check("t5_rst_empty", empty_o, 1);
        check("t5_rst_ready", st_ready_o, 0);
        check("t5_rst_misalign", misalign_o, 0);
        rst = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        check("t5_ready_release", st_ready_o, 1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) tick(acc);
        check("t5_no_stale_req", mem_req_o, 0);
        check("t5_empty_stays", empty_o, 1);

        // Continuous aligned stream with continuous grant
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_st(1'b1, 32'h0000_6000 + 32'(4 * i), 3'b010, 32'h6000_0000 + 32'(i));
            if (i > 0) begin
                check("t6_not_empty", empty_o, 0);
                check("t6_req", mem_req_o, 1);
            end
            tick(acc);
            check("t6_acc", acc, 1);
            exp_q.push_back({32'h0000_6000 + 32'(4 * i), 32'h6000_0000 + 32'(i), 4'b1111});
        end
        st_valid_i = 1'b0;
        drain("t6_drained");
        check("t6_empty_end", empty_o, 1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
